// File: rtl/fsm_req.sv
// fsm_req: buffers 4-bit jobs in a small FIFO and presents them one at a
// time on req_data as requests to a control unit. Each request is closed by a
// one-cycle ack or abandoned after TIMEOUT cycles. One idle (zero) cycle always
// separates consecutive requests so the control unit can see each one begin.
module fsm_req #(
  parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
  parameter int TIMEOUT = 64   // max REQ cycles waiting for ack, >= 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     job_valid,
  input  logic [3:0]               job_data,
  output logic                     job_ready,
  output logic [3:0]               req_data,
  input  logic                     ack,
  output logic                     busy,
  output logic                     done_pulse,
  output logic                     timeout_err,
  output logic                     drop_pulse,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [CW-1:0]   wait_cnt;

  logic accept, push, drop, pop, ack_take, to_take, wait_expired;

  // Handshake decode: a zero payload is accepted but never stored.
  assign job_ready    = (level < LEVEL_FULL);
  assign accept       = job_valid && job_ready;
  assign push         = accept && (job_data != 4'b0000);
  assign drop         = accept && (job_data == 4'b0000);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  assign fifo_level = level;
  assign busy       = (state != S_IDLE) || (level != '0);
  assign req_data   = (state == S_REQ) ? mem[rd_ptr] : 4'b0000;

  // Next-state and pop decode; ack takes priority over an expiring wait.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    pop        = 1'b0;
    ack_take   = 1'b0;
    to_take    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (level != '0) state_next = S_REQ;
      end
      S_REQ: begin
        if (ack) begin
          pop        = 1'b1;
          ack_take   = 1'b1;
          state_next = S_GAP;
        end else if (wait_expired) begin
          pop        = 1'b1;
          to_take    = 1'b1;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        state_next = (level != '0) ? S_REQ : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, pointers, occupancy, wait counter, pulses and completion count.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      wait_cnt    <= '0;
      done_cnt    <= '0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      state       <= state_next;
      done_pulse  <= ack_take;
      timeout_err <= to_take;
      drop_pulse  <= drop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // Counter is held at zero outside REQ, so it starts from zero on entry.
      if (state == S_REQ) wait_cnt <= wait_cnt + CW'(1);
      else                wait_cnt <= '0;
      if (ack_take) done_cnt <= done_cnt + 8'd1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it unreset keeps it plain RAM.
    if (push) mem[wr_ptr] <= job_data;
  end

endmodule

// File: tb/tb_fsm_req.sv
// Self-checking bench for fsm_req. Expected request payloads are queued as
// jobs are offered and popped when the DUT presents each new request.
module tb_fsm_req;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       job_valid;
  logic [3:0] job_data;
  logic       job_ready;
  logic [3:0] req_data;
  logic       ack;
  logic       busy;
  logic       done_pulse;
  logic       timeout_err;
  logic       drop_pulse;
  logic [2:0] fifo_level;
  logic [7:0] done_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_head;
  int         exp_done = 0;

  fsm_req #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .job_valid   (job_valid),
    .job_data    (job_data),
    .job_ready   (job_ready),
    .req_data    (req_data),
    .ack         (ack),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .timeout_err (timeout_err),
    .drop_pulse  (drop_pulse),
    .fifo_level  (fifo_level),
    .done_cnt    (done_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected payload, or a marker value if the queue is empty.
  task automatic next_expected(output logic [3:0] v);
    if (exp_q.size() == 0) v = 4'bxxxx;
    else                   v = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; job_valid = 1'b0; job_data = 4'h0; ack = 1'b0;
    tick(); tick();
    n_checks++; if (req_data !== 4'h0) begin n_fail++; $display("FAIL reset_req_data: got %h want 0", req_data); end
    n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({done_pulse, timeout_err, drop_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {done_pulse, timeout_err, drop_pulse}); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_single();
    int hi;
    job_valid = 1'b1; job_data = 4'hA; exp_q.push_back(4'hA);
    tick();
    job_valid = 1'b0; job_data = 4'h0;
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    n_checks++; if (req_data !== 4'h0) begin n_fail++; $display("FAIL single_early: got %h want 0", req_data); end
    tick();
    next_expected(exp_head);
    n_checks++; if (req_data !== exp_head) begin n_fail++; $display("FAIL single_latency: got %h want %h", req_data, exp_head); end
    hi = (req_data == 4'hA) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (req_data == 4'hA) hi++;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0; exp_done++;
    n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL single_req_cycles: got %0d want 4", hi); end
    n_checks++; if (req_data !== 4'h0) begin n_fail++; $display("FAIL single_gap: got %h want 0", req_data); end
    n_checks++; if (done_pulse !== 1'b1) begin n_fail++; $display("FAIL single_done_pulse: got %b want 1", done_pulse); end
    n_checks++; if (done_cnt !== 8'(exp_done)) begin n_fail++; $display("FAIL single_done_cnt: got %0d want %0d", done_cnt, exp_done); end
    tick();
    n_checks++; if ({done_pulse, busy, req_data} !== 6'b0) begin n_fail++; $display("FAIL single_idle: got pulse=%b busy=%b req=%h want 0/0/0", done_pulse, busy, req_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] jobs [4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < 4; i++) begin
      job_valid = 1'b1; job_data = jobs[i]; exp_q.push_back(jobs[i]);
      tick();
    end
    job_valid = 1'b0; job_data = 4'h0;
    n_checks++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", job_ready); end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_full_level: got %0d want 4", fifo_level); end
    for (int k = 0; k < 4; k++) begin
      next_expected(exp_head);
      n_checks++; if (req_data !== exp_head) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", k, req_data, exp_head); end
      ack = 1'b1;
      tick();
      ack = 1'b0; exp_done++;
      n_checks++; if ({req_data, done_pulse} !== 5'b0000_1) begin n_fail++; $display("FAIL b2b_gap[%0d]: got req=%h pulse=%b want 0/1", k, req_data, done_pulse); end
      tick();
    end
    n_checks++; if (done_cnt !== 8'(exp_done)) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want %0d", done_cnt, exp_done); end
    n_checks++; if ({req_data, fifo_level, job_ready} !== {4'h0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL b2b_drained: got req=%h level=%0d ready=%b want 0/0/1", req_data, fifo_level, job_ready); end
  endtask

  task automatic test_timeout();
    int cnt;
    job_valid = 1'b1; job_data = 4'h3; exp_q.push_back(4'h3);
    tick();
    job_valid = 1'b0; job_data = 4'h0;
    tick();
    next_expected(exp_head);
    n_checks++; if (req_data !== exp_head) begin n_fail++; $display("FAIL to_head: got %h want %h", req_data, exp_head); end
    cnt = (req_data == 4'h3) ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req_data == 4'h3) cnt++;
      else break;
    end
    n_checks++; if (cnt !== 64) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 64", cnt); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_pulse: got %b want 1", timeout_err); end
    n_checks++; if (done_cnt !== 8'(exp_done)) begin n_fail++; $display("FAIL to_done_cnt: got %0d want %0d", done_cnt, exp_done); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL to_level: got %0d want 0", fifo_level); end
    tick();
    n_checks++; if ({timeout_err, busy} !== 2'b00) begin n_fail++; $display("FAIL to_idle: got err=%b busy=%b want 0/0", timeout_err, busy); end
  endtask

  task automatic test_ack_boundary();
    job_valid = 1'b1; job_data = 4'h9; exp_q.push_back(4'h9);
    tick();
    job_valid = 1'b0; job_data = 4'h0;
    tick();
    next_expected(exp_head);
    n_checks++; if (req_data !== exp_head) begin n_fail++; $display("FAIL bnd_head: got %h want %h", req_data, exp_head); end
    for (int i = 0; i < 63; i++) tick();
    n_checks++; if (req_data !== 4'h9) begin n_fail++; $display("FAIL bnd_cycle64: got %h want 9", req_data); end
    ack = 1'b1;
    tick();
    ack = 1'b0; exp_done++;
    n_checks++; if ({done_pulse, timeout_err} !== 2'b10) begin n_fail++; $display("FAIL bnd_ack_wins: got done=%b err=%b want 1/0", done_pulse, timeout_err); end
    n_checks++; if (done_cnt !== 8'(exp_done)) begin n_fail++; $display("FAIL bnd_done_cnt: got %0d want %0d", done_cnt, exp_done); end
    tick(); tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if ({done_cnt, fifo_level, req_data} !== {8'(exp_done), 3'd0, 4'h0}) begin n_fail++; $display("FAIL stray_ack: got cnt=%0d level=%0d req=%h want %0d/0/0", done_cnt, fifo_level, req_data, exp_done); end
    tick();
    n_checks++; if ({done_pulse, req_data} !== 5'b0) begin n_fail++; $display("FAIL stray_ack_pulse: got pulse=%b req=%h want 0/0", done_pulse, req_data); end
  endtask

  task automatic test_drop();
    job_valid = 1'b1; job_data = 4'h0;
    tick();
    job_valid = 1'b0;
    n_checks++; if (drop_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b want 1", drop_pulse); end
    n_checks++; if ({fifo_level, req_data} !== 7'b0) begin n_fail++; $display("FAIL drop_level: got level=%0d req=%h want 0/0", fifo_level, req_data); end
    tick();
    n_checks++; if ({drop_pulse, req_data} !== 5'b0) begin n_fail++; $display("FAIL drop_once: got pulse=%b req=%h want 0/0", drop_pulse, req_data); end
  endtask

  task automatic test_reset_mid_req();
    for (int i = 1; i <= 4; i++) begin
      job_valid = 1'b1; job_data = 4'(i);
      tick();
    end
    job_valid = 1'b0; job_data = 4'h0;
    n_checks++; if (req_data !== 4'h1) begin n_fail++; $display("FAIL rst_pre: got %h want 1", req_data); end
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete(); exp_done = 0;
    n_checks++; if ({req_data, fifo_level, done_cnt} !== 15'b0) begin n_fail++; $display("FAIL rst_async: got req=%h level=%0d cnt=%0d want 0/0/0", req_data, fifo_level, done_cnt); end
    n_checks++; if ({done_pulse, timeout_err, drop_pulse, busy, job_ready} !== 5'b00001) begin n_fail++; $display("FAIL rst_outputs: got %b want 00001", {done_pulse, timeout_err, drop_pulse, busy, job_ready}); end
    tick(); tick();
    n_checks++; if ({done_pulse, timeout_err, drop_pulse} !== 3'b000) begin n_fail++; $display("FAIL rst_no_pulse: got %b want 000", {done_pulse, timeout_err, drop_pulse}); end
    @(posedge clk); #1 reset_n = 1'b1;
    job_valid = 1'b1; job_data = 4'hB; exp_q.push_back(4'hB);
    tick();
    job_valid = 1'b0; job_data = 4'h0;
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL rst_first_push: got %0d want 1", fifo_level); end
    tick();
    next_expected(exp_head);
    n_checks++; if (req_data !== exp_head) begin n_fail++; $display("FAIL rst_resume: got %h want %h", req_data, exp_head); end
    ack = 1'b1;
    tick();
    ack = 1'b0; exp_done++;
    n_checks++; if ({done_pulse, done_cnt} !== {1'b1, 8'(exp_done)}) begin n_fail++; $display("FAIL rst_resume_done: got pulse=%b cnt=%0d want 1/%0d", done_pulse, done_cnt, exp_done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_ack_boundary();
    test_drop();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
